// File: rtl/servant_uart_tx.sv
// Buffered 8N1 UART transmitter on the servant reduced Wishbone bus (FIFO + baud-timed shifter).
// Optional interrupt output and control register enabled by defining SERVANT_UART_TX_IRQ_EN.
module servant_uart_tx #(
    parameter int FIFO_DEPTH  = 16,
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 867
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [1:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
`ifdef SERVANT_UART_TX_IRQ_EN
    output logic        o_irq,
`endif
    output logic        o_tx
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    // Handshake: i_wb_cyc is the request and is held until o_wb_ack; an access is
    // accepted on the edge where cyc is high and ack is low, and ack pulses for that one cycle.
    logic access;
    logic wr_data;
    logic wr_div;
    logic rd_status;
    logic push;
    logic pop;
    logic ovf_set;

    logic [AW:0]          wr_ptr_q;
    logic [AW:0]          rd_ptr_q;
    logic [7:0]           mem [FIFO_DEPTH];
    logic                 full;
    logic                 empty;
    logic [7:0]           head;

    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] div_wr;
    logic [31:0]          sel_mask;
    logic                 ovf_q;
    logic [31:0]          rdt_d;
    logic                 unused_bus;

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [7:0]           shift_q, shift_d;
    logic                 tx_d;
    logic                 busy;

`ifdef SERVANT_UART_TX_IRQ_EN
    logic                 irq_en_q;
    logic                 wr_ctrl;
    assign wr_ctrl = access & i_wb_we & (i_wb_adr == 2'd3) & i_wb_sel[0];
`endif

    assign access    = i_wb_cyc & ~o_wb_ack;
    assign wr_data   = access & i_wb_we & (i_wb_adr == 2'd0) & i_wb_sel[0];
    assign wr_div    = access & i_wb_we & (i_wb_adr == 2'd2);
    assign rd_status = access & ~i_wb_we & (i_wb_adr == 2'd1);

    // Full is taken from the pre-edge pointers, so a pop on the same edge cannot rescue a write.
    assign push    = wr_data & ~full;
    assign ovf_set = wr_data & full;

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign head  = mem[rd_ptr_q[AW-1:0]];
    assign busy  = (state_q != ST_IDLE);

    assign sel_mask   = {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}}, {8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}};
    assign div_wr     = (div_q & ~sel_mask[DIV_WIDTH-1:0]) | (i_wb_dat[DIV_WIDTH-1:0] & sel_mask[DIV_WIDTH-1:0]);
    assign unused_bus = ^{i_wb_dat, sel_mask};

    always_comb begin
        rdt_d = '0;
        case (i_wb_adr)
            2'd1:    rdt_d = {28'd0, ovf_q, busy, empty, full};
            2'd2:    rdt_d = 32'(div_q);
`ifdef SERVANT_UART_TX_IRQ_EN
            2'd3:    rdt_d = {31'd0, irq_en_q};
`endif
            default: rdt_d = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wb_ack <= 1'b0;
            o_wb_rdt <= '0;
            div_q    <= DIV_RST;
            ovf_q    <= 1'b0;
        end else begin
            o_wb_ack <= access;
            if (access && !i_wb_we) begin
                o_wb_rdt <= rdt_d;
            end
            if (wr_div) begin
                div_q <= div_wr;
            end
            // Overflow wins over a same-edge clear so no drop goes unreported.
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (rd_status) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= i_wb_dat[7:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // The divisor is sampled only when a bit starts, so a DIV write never stretches the current bit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        tx_d    = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    cnt_d   = div_q;
                    bit_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (cnt_q == '0) begin
                    cnt_d   = div_q;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end
            end
            ST_DATA: begin
                tx_d = shift_q[0];
                if (cnt_q == '0) begin
                    cnt_d   = div_q;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (cnt_q == '0) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        cnt_d   = div_q;
                        bit_d   = '0;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line driver registered from the FSM state, so o_tx trails the state by one cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_tx <= 1'b1;
        end else begin
            o_tx <= tx_d;
        end
    end

`ifdef SERVANT_UART_TX_IRQ_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            irq_en_q <= 1'b0;
            o_irq    <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                irq_en_q <= i_wb_dat[0];
            end
            o_irq <= irq_en_q & empty & ~busy;
        end
    end
`endif

endmodule

// File: tb/tb_servant_uart_tx.sv
// Directed bench for servant_uart_tx: Wishbone driver tasks, serial frame receiver and
// an expected-byte queue; covers SERVANT_UART_TX_IRQ_EN when that macro is defined.
module tb_servant_uart_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  wb_adr = '0;
    logic [31:0] wb_dat = '0;
    logic [3:0]  wb_sel = '0;
    logic        wb_we = 1'b0;
    logic        wb_cyc = 1'b0;
    logic [31:0] wb_rdt;
    logic        wb_ack;
    logic        o_tx;
`ifdef SERVANT_UART_TX_IRQ_EN
    logic        irq;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    int l1[10]   = '{default: 1};
    int l4[10]   = '{default: 4};
    int l41[10]  = '{default: 41};
    int lchg[10] = '{4, 4, 4, 8, 8, 8, 8, 8, 8, 8};

    servant_uart_tx dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_wb_adr (wb_adr),
        .i_wb_dat (wb_dat),
        .i_wb_sel (wb_sel),
        .i_wb_we  (wb_we),
        .i_wb_cyc (wb_cyc),
        .o_wb_rdt (wb_rdt),
        .o_wb_ack (wb_ack),
`ifdef SERVANT_UART_TX_IRQ_EN
        .o_irq    (irq),
`endif
        .o_tx     (o_tx)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Bus driver: called at a falling edge, returns at a falling edge with the bus idle.
    task automatic wb_access(input logic [1:0] adr, input logic we, input logic [31:0] dat,
                             input logic [3:0] sel, output logic [31:0] rdt);
        int n;
        n = 0;
        wb_adr = adr;
        wb_we  = we;
        wb_dat = dat;
        wb_sel = sel;
        wb_cyc = 1'b1;
        @(negedge clk);
        while (!wb_ack && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("ack_latency", n, 0);
        rdt = wb_rdt;
        wb_cyc = 1'b0;
        wb_we  = 1'b0;
        @(negedge clk);
    endtask

    task automatic wb_write(input logic [1:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] dummy;
        wb_access(adr, 1'b1, dat, sel, dummy);
    endtask

    task automatic wb_read(input logic [1:0] adr, output logic [31:0] rdt);
        wb_access(adr, 1'b0, 32'h0, 4'hF, rdt);
    endtask

    task automatic write_data(input logic [7:0] b, input logic accept);
        wb_write(2'd0, {24'h0, b}, 4'hF);
        if (accept) exp_q.push_back(b);
    endtask

    // Receiver: waits up to max_wait cycles for the start bit, then requires each bit to hold
    // exactly lens[i] samples; the decoded byte is compared against the scoreboard head.
    task automatic rx_frame(input int lens[10], input int max_wait, output int w);
        logic [7:0] got;
        logic [7:0] exp_v;
        logic       ok;
        logic       v;
        w   = 0;
        ok  = 1'b1;
        got = '0;
        v   = 1'b0;
        @(negedge clk);
        while (o_tx !== 1'b0 && w < max_wait) begin
            @(negedge clk);
            w++;
        end
        check("frame_start", 32'(w < max_wait), 1);
        if (o_tx === 1'b0) begin
            for (int b = 0; b < 10; b++) begin
                for (int s = 0; s < lens[b]; s++) begin
                    if (b != 0 || s != 0) @(negedge clk);
                    if (s == 0) v = o_tx;
                    else if (o_tx !== v) ok = 1'b0;
                end
                if (b == 0 && v !== 1'b0) ok = 1'b0;
                if (b == 9 && v !== 1'b1) ok = 1'b0;
                if (b >= 1 && b <= 8) got[b-1] = v;
            end
        end
        check("frame_shape", 32'(ok), 1);
        exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        check("frame_byte", {24'h0, got}, {24'h0, exp_v});
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  b;
        int          w;
        int          bad;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(o_tx), 1);
        check("rst_ack", 32'(wb_ack), 0);
        check("rst_rdt", wb_rdt, 0);
        rst_n = 1'b1;
        @(negedge clk);
        wb_read(2'd1, rd);
        check("rst_status", rd, 32'h2);
        wb_read(2'd2, rd);
        check("rst_div", rd, 867);
        wb_read(2'd0, rd);
        check("data_read", rd, 0);
        wb_write(2'd1, 32'hFFFF_FFFF, 4'hF);
        wb_read(2'd1, rd);
        check("status_wr_ignored", rd, 32'h2);

        // Ack is a single pulse even if cyc stays high
        wb_adr = 2'd1;
        wb_we  = 1'b0;
        wb_cyc = 1'b1;
        @(negedge clk);
        check("ack_first", 32'(wb_ack), 1);
        @(negedge clk);
        check("ack_pulse", 32'(wb_ack), 0);
        wb_cyc = 1'b0;
        @(negedge clk);

`ifdef SERVANT_UART_TX_IRQ_EN
        wb_read(2'd3, rd);
        check("ctrl_rst", rd, 0);
        check("irq_rst", 32'(irq), 0);
        wb_write(2'd3, 32'h1, 4'h1);
        wb_read(2'd3, rd);
        check("ctrl_rw", rd, 1);
        wb_write(2'd3, 32'h0, 4'h1);
`else
        wb_write(2'd3, 32'hFFFF_FFFF, 4'hF);
        wb_read(2'd3, rd);
        check("reserved_read", rd, 0);
`endif

        // DIV=3, byte 0xA5, status during and after the frame
        wb_write(2'd2, 32'd3, 4'hF);
        wb_read(2'd2, rd);
        check("div_rw", rd, 3);
        write_data(8'hA5, 1'b1);
        fork
            rx_frame(l4, 4, w);
            begin
                repeat (12) @(negedge clk);
                wb_read(2'd1, rd);
                check("status_busy", rd, 32'h6);
            end
        join
        check("tx_latency", w, 0);
        wb_read(2'd1, rd);
        check("status_idle", rd, 32'h2);

        // DIV 3 -> 7 in the middle of data bit 1
        write_data(8'h55, 1'b1);
        fork
            rx_frame(lchg, 4, w);
            begin
                repeat (9) @(negedge clk);
                wb_write(2'd2, 32'd7, 4'hF);
            end
        join

        // Back-to-back frames at DIV=0
        wb_write(2'd2, 32'd0, 4'hF);
        write_data(8'hC3, 1'b1);
        fork
            rx_frame(l1, 4, w);
            write_data(8'h3C, 1'b1);
        join
        rx_frame(l1, 1, w);

        // Overflow: one byte in flight, sixteen buffered, the next one dropped
        wb_write(2'd2, 32'd40, 4'hF);
        b = 8'($urandom_range(0, 255));
        write_data(b, 1'b1);
        fork
            rx_frame(l41, 4, w);
            begin
                for (int i = 0; i < 16; i++) begin
                    b = 8'($urandom_range(0, 255));
                    write_data(b, 1'b1);
                end
                wb_read(2'd1, rd);
                check("status_full", rd, 32'h5);
                b = 8'($urandom_range(0, 255));
                write_data(b, 1'b0);
                wb_read(2'd1, rd);
                check("status_ovf", rd, 32'hD);
                wb_read(2'd1, rd);
                check("status_ovf_clr", rd, 32'h5);
            end
        join
        for (int i = 0; i < 16; i++) rx_frame(l41, 1, w);
        wb_read(2'd1, rd);
        check("status_drained", rd, 32'h2);

        // Byte selects on DIV
        wb_write(2'd2, 32'hFFFF_FFFF, 4'b0001);
        wb_read(2'd2, rd);
        check("div_sel0", rd, 32'h00FF);
        wb_write(2'd2, 32'h1234_5678, 4'b0010);
        wb_read(2'd2, rd);
        check("div_sel1", rd, 32'h56FF);

`ifdef SERVANT_UART_TX_IRQ_EN
        wb_write(2'd2, 32'd3, 4'hF);
        check("irq_disabled", 32'(irq), 0);
        wb_write(2'd3, 32'h1, 4'h1);
        check("irq_idle", 32'(irq), 1);
        write_data(8'h5A, 1'b1);
        check("irq_drop_write", 32'(irq), 0);
        fork
            rx_frame(l4, 4, w);
            begin
                repeat (20) @(negedge clk);
                check("irq_mid_frame", 32'(irq), 0);
            end
        join
        check("irq_last_stop", 32'(irq), 0);
        @(negedge clk);
        check("irq_rise", 32'(irq), 1);
        write_data(8'h0F, 1'b1);
        check("irq_drop_again", 32'(irq), 0);
        rx_frame(l4, 4, w);
`endif
        check("sb_empty", exp_q.size(), 0);

        // Asynchronous reset in the middle of a frame with a byte still queued
        wb_write(2'd2, 32'd3, 4'hF);
        write_data(8'h00, 1'b1);
        write_data(8'h00, 1'b1);
        repeat (6) @(negedge clk);
        check("tx_low_mid_frame", 32'(o_tx), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("tx_async_rst", 32'(o_tx), 1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wb_read(2'd1, rd);
        check("status_after_rst", rd, 32'h2);
        wb_read(2'd2, rd);
        check("div_after_rst", rd, 867);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (o_tx !== 1'b1) bad++;
        end
        check("tx_quiet_after_rst", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
